fetch_decode_buffer: RTL and testbench
======================================

Name: fetch_decode_buffer

Overview:
- Decoupling buffer between the fetch stage and the decode stage of the core.
- Captures the instruction word, PC and PC+4 from fetch, holds up to DEPTH entries, and presents the oldest one to decode through a valid/ready handshake.
- Absorbs the one-cycle in-flight read of the synchronous instruction ROM when decode stalls.
- Generates the halt request back to the PC unit, and squashes wrong-path instructions on a redirect.

Parameters:
WIDTH, 32, data/address width of instruction and PC fields
DEPTH, 2, number of buffered entries (minimum 2)
NOP_INSTR, 32'h00000013, instruction presented when no valid entry (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
instr_in  input  WIDTH  instruction word from ROM
pc_in  input  WIDTH  PC associated with instr_in
pcPlus4_in  input  WIDTH  PC+4 associated with instr_in
in_valid  input  1  instr_in/pc_in/pcPlus4_in carry a real fetched instruction this cycle
flush  input  1  redirect taken (pc_src); discard all buffered and in-flight instructions
out_ready  input  1  decode accepts the head entry this cycle
instr_out  output  WIDTH  head instruction, or NOP_INSTR when not valid
pc_out  output  WIDTH  head PC, 0 when not valid
pcPlus4_out  output  WIDTH  head PC+4, 0 when not valid
out_valid  output  1  head entry is valid
fetch_halt  output  1  request to freeze the PC (drives pc_halt)
occupancy  output  clog2(DEPTH+1)  number of valid entries
overflow_err  output  1  sticky: a push was dropped because the buffer was full

Behaviour:
- Reset (rst=0, asynchronous):
  - occupancy=0, out_valid=0, instr_out=NOP_INSTR, pc_out=0, pcPlus4_out=0.
  - fetch_halt=0, overflow_err=0, squash register=0, read/write pointers=0.
- Storage:
  - Circular buffer of DEPTH entries {instr, pc, pcPlus4}.
  - Read and write pointers wrap modulo DEPTH.
  - Outputs are driven combinationally from the head entry, so latency from push to out_valid is 1 cycle.
- Effective push: push = in_valid && !flush && !squash.
- Pop: pop = out_valid && out_ready.
- Same-cycle push and pop:
  - Non-empty buffer: both take effect and occupancy is unchanged.
  - Empty buffer: no pop; push only.
- Full buffer (occupancy==DEPTH):
  - push with pop: accepted.
  - push without pop: entry dropped, overflow_err set to 1 (sticky until reset), state otherwise unchanged.
- fetch_halt = (occupancy >= DEPTH-1) && !pop, combinational.
  - This guarantees one free slot for the instruction already in flight from the synchronous ROM.
- Flush has priority over everything except reset. On a rising edge with flush=1:
  - occupancy←0 and pointers←0.
  - Same-cycle push and pop are ignored (decode must not consume while flush=1).
  - squash←1.
- Squash:
  - The cycle after a flush, in_valid is ignored, because that ROM data belongs to the wrong path.
  - squash clears on the following edge unless flush is asserted again.
  - Back-to-back flushes keep squash=1.
- overflow_err is unaffected by flush.
- Invalid outputs: when out_valid=0, instr_out=NOP_INSTR and pc/pcPlus4 outputs=0 regardless of stale storage.
- occupancy never exceeds DEPTH and never underflows. A pop when empty is impossible because out_valid=0.

Test Plan:
- Reset and flow-through: release rst, out_ready=1, push pc 0x0,0x4,0x8 with instrs 0x00500093,0x00a00113,0x002081b3 on consecutive cycles.
  -> Each appears one cycle later in order with out_valid=1; occupancy stays ≤1; fetch_halt=0.
- Stall absorbs in-flight: out_ready=0 after pc 0x0 enters.
  -> fetch_halt=1 when occupancy=1.
  -> The in-flight pc 0x4 is still accepted (occupancy=2), with no overflow_err.
  -> Raising out_ready drains 0x0 then 0x4.
- Overflow: out_ready=0, force in_valid=1 for 3 cycles with DEPTH=2.
  -> Third push dropped; overflow_err=1 and stays 1 after a flush; head remains the first entry.
- Flush with squash: buffer holds pc 0x10,0x14; assert flush 1 cycle with in_valid=1.
  -> Next cycle occupancy=0, out_valid=0, instr_out=0x00000013.
  -> Data with in_valid=1 the cycle after the flush (pc 0x18) is discarded.
  -> Data two cycles after the flush (pc 0x40) is accepted.
- Simultaneous push/pop when full: occupancy=2, out_ready=1, in_valid=1.
  -> occupancy stays 2, head advances, no overflow_err; pointers wrap correctly over 5 such cycles.
- Asynchronous reset mid-operation: drop rst between clock edges with occupancy=2.
  -> All outputs take their reset values immediately, without waiting for a clock edge.
  -> The first push after release appears at the head.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode decoupling buffer: a small circular queue of {instr, pc, pc+4}
// with valid/ready hand-off to decode, PC halt request and redirect squash.
module fetch_decode_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP_INSTR = 'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             instr_in,
  input  logic [WIDTH-1:0]             pc_in,
  input  logic [WIDTH-1:0]             pcPlus4_in,
  input  logic                         in_valid,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             instr_out,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             pcPlus4_out,
  output logic                         out_valid,
  output logic                         fetch_halt,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow_err
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] HALT_LVL = OCC_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] pc4_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             squash;
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (occupancy != '0);
  assign full      = (occupancy == FULL_LVL);
  assign push      = in_valid && !flush && !squash;
  assign pop       = out_valid && out_ready;
  assign accept    = push && (!full || pop);

  // Halting one entry early leaves room for the word the synchronous ROM is already reading.
  assign fetch_halt = (occupancy >= HALT_LVL) && !pop;

  assign instr_out   = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
  assign pc_out      = out_valid ? pc_mem[rd_ptr]    : '0;
  assign pcPlus4_out = out_valid ? pc4_mem[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      instr_mem[wr_ptr] <= instr_in;
      pc_mem[wr_ptr]    <= pc_in;
      pc4_mem[wr_ptr]   <= pcPlus4_in;
    end
  end

  // Flush wins over push/pop; overflow_err is deliberately left untouched by it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy    <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      squash       <= 1'b0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      occupancy <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      squash    <= 1'b1;
    end else begin
      squash <= 1'b0;
      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (accept && !pop) occupancy <= occupancy + 1'b1;
      else if (pop && !accept) occupancy <= occupancy - 1'b1;
      if (push && full && !pop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: stimulus queues expected head entries,
// a negedge monitor compares them whenever decode consumes one.
module tb_fetch_decode_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] pcPlus4_in;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcPlus4_out;
  logic        out_valid;
  logic        fetch_halt;
  logic [1:0]  occupancy;
  logic        overflow_err;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  fetch_decode_buffer #(.WIDTH(32), .DEPTH(2), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst),
    .instr_in(instr_in), .pc_in(pc_in), .pcPlus4_in(pcPlus4_in),
    .in_valid(in_valid), .flush(flush), .out_ready(out_ready),
    .instr_out(instr_out), .pc_out(pc_out), .pcPlus4_out(pcPlus4_out),
    .out_valid(out_valid), .fetch_halt(fetch_halt),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; expAcc says whether this word should reach decode.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic rdy, input logic fl, input logic expAcc);
    in_valid   = v;
    instr_in   = instr;
    pc_in      = pc;
    pcPlus4_in = pc + 32'd4;
    out_ready  = rdy;
    flush      = fl;
    if (fl) expQ.delete();
    if (expAcc) expQ.push_back('{instr: instr, pc: pc});
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode consumes the head on the next edge whenever valid && ready.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      entry_t e;
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pop: got pc 0x%08h expected no valid entry", pc_out);
      end else begin
        e = expQ.pop_front();
        checkOutput("pop_instr", instr_out, e.instr);
        checkOutput("pop_pc", pc_out, e.pc);
        checkOutput("pop_pc4", pcPlus4_out, e.pc + 32'd4);
      end
    end
  end

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #12;
    checkOutput("rst_occ", 32'(occupancy), 0);
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_instr", instr_out, 32'h00000013);
    checkOutput("rst_pc", pc_out, 0);
    checkOutput("rst_pc4", pcPlus4_out, 0);
    checkOutput("rst_halt", 32'(fetch_halt), 0);
    checkOutput("rst_ovf", 32'(overflow_err), 0);
    rst = 1'b1;
    tick();

    // Flow-through with decode always ready
    applyStimulus(1, 32'h00500093, 32'h0, 1, 0, 1);
    checkOutput("flow_halt0", 32'(fetch_halt), 0);
    tick();
    applyStimulus(1, 32'h00a00113, 32'h4, 1, 0, 1);
    checkOutput("flow_occ1", 32'(occupancy), 1);
    checkOutput("flow_halt1", 32'(fetch_halt), 0);
    tick();
    applyStimulus(1, 32'h002081b3, 32'h8, 1, 0, 1);
    checkOutput("flow_occ2", 32'(occupancy), 1);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("flow_empty", 32'(occupancy), 0);

    // Stall: in-flight word still absorbed
    applyStimulus(1, 32'h00500093, 32'h0, 0, 0, 1);
    tick();
    applyStimulus(1, 32'h00a00113, 32'h4, 0, 0, 1);
    checkOutput("stall_halt", 32'(fetch_halt), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stall_occ", 32'(occupancy), 2);
    checkOutput("stall_ovf", 32'(overflow_err), 0);
    checkOutput("stall_head", pc_out, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stall_drained", 32'(occupancy), 0);

    // Full buffer with simultaneous push and pop, pointers wrapping
    applyStimulus(1, 32'h11100000, 32'h200, 0, 0, 1);
    tick();
    applyStimulus(1, 32'h11100004, 32'h204, 0, 0, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 32'h11100008 + 32'(4 * k), 32'h208 + 32'(4 * k), 1, 0, 1);
      checkOutput("full_occ", 32'(occupancy), 2);
      checkOutput("full_halt", 32'(fetch_halt), 0);
      checkOutput("full_ovf", 32'(overflow_err), 0);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("full_drained", 32'(occupancy), 0);

    // Overflow: third push dropped, flag sticky across flush
    applyStimulus(1, 32'hAAAA0000, 32'h100, 0, 0, 1);
    tick();
    applyStimulus(1, 32'hAAAA0004, 32'h104, 0, 0, 1);
    tick();
    applyStimulus(1, 32'hAAAA0008, 32'h108, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ovf_flag", 32'(overflow_err), 1);
    checkOutput("ovf_occ", 32'(occupancy), 2);
    checkOutput("ovf_head", pc_out, 32'h100);
    checkOutput("ovf_head_instr", instr_out, 32'hAAAA0000);
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ovf_after_flush", 32'(overflow_err), 1);
    checkOutput("ovf_flush_occ", 32'(occupancy), 0);
    tick();

    // Flush with squash of the wrong-path ROM word
    applyStimulus(1, 32'hBBBB0010, 32'h10, 0, 0, 1);
    tick();
    applyStimulus(1, 32'hBBBB0014, 32'h14, 0, 0, 1);
    tick();
    applyStimulus(1, 32'hBBBB0099, 32'h99, 0, 1, 0);
    tick();
    applyStimulus(1, 32'hBBBB0018, 32'h18, 0, 0, 0);
    checkOutput("flush_occ", 32'(occupancy), 0);
    checkOutput("flush_valid", 32'(out_valid), 0);
    checkOutput("flush_nop", instr_out, 32'h00000013);
    checkOutput("flush_pc", pc_out, 0);
    tick();
    applyStimulus(1, 32'hBBBB0040, 32'h40, 0, 0, 1);
    checkOutput("squash_occ", 32'(occupancy), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_squash_occ", 32'(occupancy), 1);
    checkOutput("post_squash_pc", pc_out, 32'h40);
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();

    // Asynchronous reset mid-operation
    applyStimulus(1, 32'hCCCC0300, 32'h300, 0, 0, 1);
    tick();
    applyStimulus(1, 32'hCCCC0304, 32'h304, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("arst_pre_occ", 32'(occupancy), 2);
    #1;
    rst = 1'b0;
    expQ.delete();
    #1;
    checkOutput("arst_occ", 32'(occupancy), 0);
    checkOutput("arst_valid", 32'(out_valid), 0);
    checkOutput("arst_instr", instr_out, 32'h00000013);
    checkOutput("arst_pc4", pcPlus4_out, 0);
    checkOutput("arst_ovf", 32'(overflow_err), 0);
    checkOutput("arst_halt", 32'(fetch_halt), 0);
    tick();
    rst = 1'b1;
    applyStimulus(1, 32'hDDDD0500, 32'h500, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("arst_first_pc", pc_out, 32'h500);
    checkOutput("arst_first_occ", 32'(occupancy), 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
